uart_rx_oversampled: RTL

//   UART receiver directly downstream of the baud tick generator; consumes its 16x-oversample

---
 rtl/uart_rx_oversampled.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversampled
// Brief    : 16x-oversampled UART receiver with start-bit validation,
//            optional parity and stop-bit checking.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int   c_MAX_TICKS = (SB_TICKS > 16) ? SB_TICKS : 16;
    localparam int   c_CNT_W     = $clog2(c_MAX_TICKS);
    localparam int   c_BIT_W     = $clog2(DATA_BITS);
    localparam logic c_PAR_EN    = (PARITY_EN != 0);
    localparam logic c_PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_CNT_W-1:0]   r_s_cnt;
    logic [c_BIT_W-1:0]   r_n;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_pbit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;

    logic w_mid;
    logic w_full;
    logic w_stop_end;
    logic w_last_bit;
    logic w_perr;
    logic w_ferr;

    assign w_mid      = (r_s_cnt == c_CNT_W'(7));
    assign w_full     = (r_s_cnt == c_CNT_W'(15));
    assign w_stop_end = (r_s_cnt == c_CNT_W'(SB_TICKS - 1));
    assign w_last_bit = (r_n == c_BIT_W'(DATA_BITS - 1));
    assign w_perr     = c_PAR_EN & ((^r_shreg ^ r_pbit) != c_PAR_ODD);
    assign w_ferr     = ~r_rx_s;

    // Two-flop synchroniser; idles high so reset does not look like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (!r_rx_s) w_state_next = c_START;
            end
            c_START: begin
                if (tick && w_mid) w_state_next = r_rx_s ? c_IDLE : c_DATA;
            end
            c_DATA: begin
                if (tick && w_full && w_last_bit)
                    w_state_next = c_PAR_EN ? c_PARITY : c_STOP;
            end
            c_PARITY: begin
                if (tick && w_full) w_state_next = c_STOP;
            end
            c_STOP: begin
                if (tick && w_stop_end) w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_cnt   <= '0;
            r_n       <= '0;
            r_shreg   <= '0;
            r_pbit    <= 1'b0;
            r_rx_data <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!r_rx_s) r_s_cnt <= '0;
                end
                c_START: begin
                    if (tick) begin
                        if (w_mid) begin
                            r_s_cnt <= '0;
                            r_n     <= '0;
                        end else begin
                            r_s_cnt <= r_s_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_DATA: begin
                    if (tick) begin
                        if (w_full) begin
                            r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_s_cnt <= '0;
                            if (!w_last_bit) r_n <= r_n + c_BIT_W'(1);
                        end else begin
                            r_s_cnt <= r_s_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_PARITY: begin
                    if (tick) begin
                        if (w_full) begin
                            r_pbit  <= r_rx_s;
                            r_s_cnt <= '0;
                        end else begin
                            r_s_cnt <= r_s_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_STOP: begin
                    if (tick) begin
                        if (w_stop_end) begin
                            // Data is published even for errored frames
                            r_rx_data <= r_shreg;
                            r_valid   <= ~w_ferr & ~w_perr;
                            r_ferr    <= w_ferr;
                            r_perr    <= w_perr;
                            r_s_cnt   <= '0;
                        end else begin
                            r_s_cnt <= r_s_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: r_s_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != c_IDLE);
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;

endmodule
`default_nettype wire
